// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - anti-diagonal wavefront dispatcher of Smith-Waterman tiles to a solver pool
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   start                      begins a grid (accepted only in IDLE)
//   cfg_rows_m1, cfg_cols_m1   grid size minus one, sampled on an accepted start
//   solver_done                per-solver completion pulses, several may coincide
//   solver_start               one-hot dispatch pulse (registered)
//   tile_row, tile_col         coordinates of the dispatched tile, held between dispatches
//   busy                       high while a grid is in progress (RUN and DONE)
//   all_done                   one-cycle pulse when the whole grid has completed
//   err                        sticky: a completion arrived from a solver holding no tile
module tile_scheduler #(
    parameter int NUM_SOLVERS = 16,
    parameter int MAX_DIM     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             cfg_rows_m1,
    input  logic [3:0]             cfg_cols_m1,
    input  logic [NUM_SOLVERS-1:0] solver_done,
    output logic [NUM_SOLVERS-1:0] solver_start,
    output logic [3:0]             tile_row,
    output logic [3:0]             tile_col,
    output logic                   busy,
    output logic                   all_done,
    output logic                   err
);
    localparam int SW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [4:0]             rows;
    logic [4:0]             cols;
    logic [4:0]             disp_cnt [MAX_DIM];
    logic [4:0]             done_cnt [MAX_DIM];
    logic [NUM_SOLVERS-1:0] sbusy;
    logic [3:0]             srow [NUM_SOLVERS];

    logic [MAX_DIM-1:0]     row_elig;
    logic [MAX_DIM-1:0]     row_fin;
    logic [MAX_DIM-1:0]     row_inc;
    logic                   grid_fin;
    logic                   pick_row_ok;
    logic [3:0]             pick_row;
    logic                   pick_sol_ok;
    logic [SW-1:0]          pick_sol;
    logic [NUM_SOLVERS-1:0] pick_vec;
    logic [NUM_SOLVERS-1:0] good_done;
    logic [NUM_SOLVERS-1:0] stray_done;

    assign good_done  = solver_done & sbusy;
    assign stray_done = solver_done & ~sbusy;

    // A row may issue its next tile when it has nothing outstanding and the
    // row above has already completed the column about to be issued.
    for (genvar g = 0; g < MAX_DIM; g++) begin : g_row
        logic prev_ok;
        if (g == 0) begin : g_first
            assign prev_ok = 1'b1;
        end else begin : g_rest
            assign prev_ok = done_cnt[g-1] > disp_cnt[g];
        end
        assign row_elig[g] = (state == S_RUN) && (5'(g) < rows) &&
                             (disp_cnt[g] < cols) &&
                             (disp_cnt[g] == done_cnt[g]) && prev_ok;
        assign row_fin[g]  = (5'(g) >= rows) || (done_cnt[g] == cols);
    end

    assign grid_fin = &row_fin;

    // Simultaneous completions always belong to distinct rows, so a per-row
    // increment flag is enough to apply all of them in one cycle.
    always_comb begin
        row_inc = '0;
        for (int s = 0; s < NUM_SOLVERS; s++) begin
            if (good_done[s]) begin
                row_inc[srow[s]] = 1'b1;
            end
        end
    end

    // Descending scans: the last hit written is the lowest index.
    always_comb begin
        pick_row_ok = 1'b0;
        pick_row    = '0;
        for (int r = MAX_DIM - 1; r >= 0; r--) begin
            if (row_elig[r]) begin
                pick_row_ok = 1'b1;
                pick_row    = 4'(r);
            end
        end
    end

    always_comb begin
        pick_sol_ok = 1'b0;
        pick_sol    = '0;
        for (int s = NUM_SOLVERS - 1; s >= 0; s--) begin
            if (!sbusy[s]) begin
                pick_sol_ok = 1'b1;
                pick_sol    = SW'(s);
            end
        end
        pick_vec = '0;
        if (pick_sol_ok) begin
            pick_vec[pick_sol] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rows         <= '0;
            cols         <= '0;
            sbusy        <= '0;
            solver_start <= '0;
            tile_row     <= '0;
            tile_col     <= '0;
            busy         <= 1'b0;
            all_done     <= 1'b0;
            err          <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                disp_cnt[r] <= '0;
                done_cnt[r] <= '0;
            end
            for (int s = 0; s < NUM_SOLVERS; s++) begin
                srow[s] <= '0;
            end
        end else begin
            solver_start <= '0;
            all_done     <= 1'b0;

            // Completion bookkeeping runs in every state; a stray done is
            // flagged and otherwise dropped.
            if (|stray_done) begin
                err <= 1'b1;
            end
            for (int s = 0; s < NUM_SOLVERS; s++) begin
                if (good_done[s]) begin
                    sbusy[s] <= 1'b0;
                end
            end
            for (int r = 0; r < MAX_DIM; r++) begin
                if (row_inc[r]) begin
                    done_cnt[r] <= done_cnt[r] + 5'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    // These clears are written last so they win over the
                    // completion updates above.
                    if (start) begin
                        rows  <= {1'b0, cfg_rows_m1} + 5'd1;
                        cols  <= {1'b0, cfg_cols_m1} + 5'd1;
                        sbusy <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                        for (int r = 0; r < MAX_DIM; r++) begin
                            disp_cnt[r] <= '0;
                            done_cnt[r] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (grid_fin) begin
                        all_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (pick_row_ok && pick_sol_ok) begin
                        solver_start       <= pick_vec;
                        tile_row           <= pick_row;
                        tile_col           <= disp_cnt[pick_row][3:0];
                        sbusy[pick_sol]    <= 1'b1;
                        srow[pick_sol]     <= pick_row;
                        disp_cnt[pick_row] <= disp_cnt[pick_row] + 5'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - randomized bench for tile_scheduler against a tile-grid reference model
module tb_tile_scheduler;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cfg_r;
    logic [3:0]  cfg_c;
    logic [15:0] done_v;
    bit          sel;

    logic        start_a, start_b;
    logic [15:0] done_a;
    logic [1:0]  done_b;
    logic [15:0] ss_a;
    logic [1:0]  ss_b;
    logic [3:0]  tr_a, tc_a, tr_b, tc_b;
    logic        busy_a, ad_a, err_a, busy_b, ad_b, err_b;

    logic [15:0] o_ss;
    logic [3:0]  o_row, o_col;
    logic        o_busy, o_ad, o_err;

    always #5 clk = ~clk;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign done_a  = sel ? 16'd0 : done_v;
    assign done_b  = sel ? done_v[1:0] : 2'd0;

    always_comb begin
        if (sel) begin
            o_ss = {14'd0, ss_b}; o_row = tr_b; o_col = tc_b;
            o_busy = busy_b; o_ad = ad_b; o_err = err_b;
        end else begin
            o_ss = ss_a; o_row = tr_a; o_col = tc_a;
            o_busy = busy_a; o_ad = ad_a; o_err = err_a;
        end
    end

    tile_scheduler #(.NUM_SOLVERS(16), .MAX_DIM(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .cfg_rows_m1(cfg_r), .cfg_cols_m1(cfg_c), .solver_done(done_a),
        .solver_start(ss_a), .tile_row(tr_a), .tile_col(tc_a),
        .busy(busy_a), .all_done(ad_a), .err(err_a)
    );

    tile_scheduler #(.NUM_SOLVERS(2), .MAX_DIM(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .cfg_rows_m1(cfg_r), .cfg_cols_m1(cfg_c), .solver_done(done_b),
        .solver_start(ss_b), .tile_row(tr_b), .tile_col(tc_b),
        .busy(busy_b), .all_done(ad_b), .err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which tiles are issued / completed, who holds what.
    bit m_disp [16][16];
    bit m_comp [16][16];
    bit hold [16];
    int hr [16];
    int hc [16];
    int due [16];
    int log_r[$], log_c[$], log_s[$], log_t[$];
    int n_disp, n_ad, ad_cycle;

    // Start in the call cycle (cycle 0); emulated solvers answer after a
    // random latency, optionally rounded up to a multiple of 'align' so that
    // several finish together. spur_at injects a done on idle solver 7,
    // restart_at pulses start mid-run, abort_at returns early.
    task automatic run_grid(input int nr, input int nc, input int nsol, input int lmin,
                            input int lmax, input int align, input int spur_at,
                            input int restart_at, input int abort_at);
        int phase, nphase, end_at, fr, fcol, fs, c0, lat, exp_r, exp_c, exp_s, orr, occ, osi;
        bit outstanding, all_c, st, finished, spur_pending, spur_now, m_err;
        bit exp_ad, exp_busy, exp_err, dep_ok;
        logic [15:0] exp_vec, dv, pend, hmask;

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                m_disp[r][c] = 1'b0;
                m_comp[r][c] = 1'b0;
            end
        for (int s = 0; s < 16; s++) begin
            hold[s] = 1'b0; hr[s] = 0; hc[s] = 0; due[s] = -1;
        end
        log_r.delete(); log_c.delete(); log_s.delete(); log_t.delete();
        n_disp = 0; n_ad = 0; ad_cycle = -1;
        phase = P_IDLE; nphase = P_IDLE; end_at = -1; finished = 1'b0;
        spur_pending = (spur_at >= 0); m_err = 1'b0;
        exp_vec = '0; exp_r = 0; exp_c = 0; exp_s = 0; pend = '0;
        exp_ad = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
        cfg_r = 4'(nr - 1);
        cfg_c = 4'(nc - 1);

        for (int n = 0; n < 6000; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
                hmask = '0;
                for (int s = 0; s < 16; s++) hmask[s] = hold[s];
                check_eq("solver_start", 32'(o_ss), 32'(exp_vec));
                check_eq("start_to_busy_solver", 32'(o_ss & hmask), 32'd0);
                if (exp_vec != '0) begin
                    check_eq("tile_row", 32'(o_row), 32'(exp_r));
                    check_eq("tile_col", 32'(o_col), 32'(exp_c));
                end
                check_eq("all_done", 32'(o_ad), 32'(exp_ad));
                check_eq("busy", 32'(o_busy), 32'(exp_busy));
                check_eq("err", 32'(o_err), 32'(exp_err));
                if (o_ss != '0) begin
                    orr = int'(o_row);
                    occ = int'(o_col);
                    osi = 0;
                    for (int s = 0; s < 16; s++) if (o_ss[s]) osi = s;
                    n_disp++;
                    log_r.push_back(orr); log_c.push_back(occ);
                    log_s.push_back(osi); log_t.push_back(n);
                    check_eq("tile_once", 32'(m_disp[orr][occ]), 32'd0);
                    dep_ok = (orr == 0 || m_comp[orr-1][occ]) && (occ == 0 || m_comp[orr][occ-1]);
                    check_eq("deps_complete", 32'(dep_ok), 32'd1);
                end
                if (o_ad) begin
                    n_ad++;
                    ad_cycle = n;
                end
                if (n == end_at) finished = 1'b1;
                if (n == abort_at) begin
                    start = 1'b0;
                    done_v = '0;
                    return;
                end
            end
            if (finished) break;

            if (exp_vec != '0) begin
                m_disp[exp_r][exp_c] = 1'b1;
                hold[exp_s] = 1'b1;
                hr[exp_s] = exp_r;
                hc[exp_s] = exp_c;
                lat = int'($urandom_range(lmax, lmin));
                due[exp_s] = n + lat;
                if (align > 0) due[exp_s] = ((due[exp_s] + align - 1) / align) * align;
            end
            phase = nphase;
            for (int s = 0; s < 16; s++) begin
                if (pend[s]) begin
                    m_comp[hr[s]][hc[s]] = 1'b1;
                    hold[s] = 1'b0;
                end
            end

            st = (n == 0) || (n == restart_at);
            dv = '0;
            for (int s = 0; s < nsol; s++) if (hold[s] && due[s] == n) dv[s] = 1'b1;
            pend = dv;
            spur_now = 1'b0;
            if (spur_pending && n >= spur_at && !hold[7]) begin
                dv[7] = 1'b1;
                spur_now = 1'b1;
                spur_pending = 1'b0;
            end

            nphase = phase;
            exp_vec = '0;
            exp_ad = 1'b0;
            if (phase == P_IDLE && st) begin
                nphase = P_RUN;
            end else if (phase == P_DONE) begin
                nphase = P_IDLE;
            end else if (phase == P_RUN) begin
                all_c = 1'b1;
                for (int r = 0; r < nr; r++)
                    for (int c = 0; c < nc; c++)
                        if (!m_comp[r][c]) all_c = 1'b0;
                if (all_c) begin
                    nphase = P_DONE;
                    exp_ad = 1'b1;
                    end_at = n + 2;
                end else begin
                    fr = -1; fcol = 0;
                    for (int r = 0; r < nr; r++) begin
                        if (fr < 0) begin
                            outstanding = 1'b0;
                            c0 = nc;
                            for (int c = 0; c < nc; c++) begin
                                if (m_disp[r][c] && !m_comp[r][c]) outstanding = 1'b1;
                                if (!m_disp[r][c] && c0 == nc) c0 = c;
                            end
                            if (!outstanding && c0 < nc && (r == 0 || m_comp[r-1][c0])) begin
                                fr = r;
                                fcol = c0;
                            end
                        end
                    end
                    fs = -1;
                    for (int s = 0; s < nsol; s++) if (fs < 0 && !hold[s]) fs = s;
                    if (fr >= 0 && fs >= 0) begin
                        exp_vec[fs] = 1'b1;
                        exp_r = fr; exp_c = fcol; exp_s = fs;
                    end
                end
            end
            exp_err = (phase == P_IDLE && st) ? 1'b0 : (m_err | spur_now);
            m_err = exp_err;
            exp_busy = (nphase != P_IDLE);

            start = st;
            done_v = dv;
        end
        start = 1'b0;
        done_v = '0;
        check_eq("run_timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; done_v = '0; sel = 1'b0; cfg_r = '0; cfg_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_a", {ss_a, tr_a, tc_a, 1'b0, busy_a, ad_a, err_a}, 32'd0);
        check_eq("reset_b", {14'd0, ss_b, tr_b, tc_b, busy_b, ad_b, err_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1x1: dispatch cycle 2, done cycle 5, all_done cycle 7, busy low 8
        run_grid(1, 1, 16, 3, 3, 0, -1, -1, -1);
        check_eq("g1_dispatches", 32'(n_disp), 32'd1);
        check_eq("g1_first_cycle", (log_t.size() > 0) ? 32'(log_t[0]) : 32'hFFFF, 32'd2);
        check_eq("g1_all_done_cycle", 32'(ad_cycle), 32'd7);

        // 2x2 with 3-cycle solvers
        run_grid(2, 2, 16, 3, 3, 0, -1, -1, -1);
        check_eq("g2_dispatches", 32'(n_disp), 32'd4);
        if (log_r.size() == 4) begin
            check_eq("g2_order", 32'((log_r[0] << 12) | (log_c[0] << 8) | (log_r[1] << 4) | log_c[1]), 32'h0001);
            check_eq("g2_order2", 32'((log_r[2] << 12) | (log_c[2] << 8) | (log_r[3] << 4) | log_c[3]), 32'h1011);
            check_eq("g2_solvers", 32'((log_s[0] << 8) | (log_s[1] << 4) | log_s[2]), 32'h001);
            check_eq("g2_back_to_back", 32'(log_t[2] - log_t[1]), 32'd1);
        end else begin
            check_eq("g2_log_size", 32'(log_r.size()), 32'd4);
        end

        // 16x16, random latencies
        run_grid(16, 16, 16, 1, 20, 0, -1, -1, -1);
        check_eq("g16_dispatches", 32'(n_disp), 32'd256);
        check_eq("g16_all_done_once", 32'(n_ad), 32'd1);

        // two-solver instance, completions aligned so both finish together
        sel = 1'b1;
        #1;
        run_grid(4, 4, 2, 1, 3, 8, -1, -1, -1);
        check_eq("ns2_dispatches", 32'(n_disp), 32'd16);
        check_eq("ns2_all_done_once", 32'(n_ad), 32'd1);
        sel = 1'b0;
        #1;

        // spurious done on idle solver 7 and a start during RUN
        run_grid(4, 4, 16, 2, 6, 0, 4, 5, -1);
        check_eq("spur_dispatches", 32'(n_disp), 32'd16);
        check_eq("spur_err_sticky", 32'(o_err), 32'd1);

        // reset in the middle of an 8x8 run
        run_grid(8, 8, 16, 1, 6, 0, -1, -1, 25);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midreset_a", {ss_a, tr_a, tc_a, 1'b0, busy_a, ad_a, err_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        done_v = 16'h0001;
        @(posedge clk);
        #1;
        done_v = '0;
        check_eq("inflight_err", 32'(o_err), 32'd1);

        run_grid(2, 2, 16, 1, 4, 0, -1, -1, -1);
        check_eq("post_reset_dispatches", 32'(n_disp), 32'd4);
        check_eq("post_reset_all_done", 32'(n_ad), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

- Dispatches Smith-Waterman tiles of a runtime-sized grid (up to 16×16) to a pool of up to 16 solvers.
- Dispatch order is an anti-diagonal wavefront: a tile is issued only after its upper and left neighbours have completed.
- Tracks which solver holds which tile, recycles solvers as they finish, and signals when the whole grid is complete.
- Sits upstream of the solvers; the result organizer consumes the solvers' outputs independently.

## Interface
- NUM_SOLVERS, 16: number of solver instances, 1..16.
- MAX_DIM, 16: maximum tiles per grid side; the row/column fields below are 4 bits wide.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a grid; honoured only in IDLE.
- cfg_rows_m1  in  4  grid rows minus 1; sampled on an accepted start.
- cfg_cols_m1  in  4  grid columns minus 1; sampled on an accepted start.
- solver_done  in  NUM_SOLVERS  per-solver completion pulse; several bits may be high in the same cycle.
- solver_start  out  NUM_SOLVERS  one-hot, single-cycle dispatch pulse.
- tile_row  out  4  row of the dispatched tile; valid while solver_start is nonzero.
- tile_col  out  4  column of the dispatched tile; valid while solver_start is nonzero.
- busy  out  1  high in RUN and DONE.
- all_done  out  1  high for exactly one cycle, in DONE.
- err  out  1  sticky flag: solver_done asserted for a solver that is not busy. Cleared only by reset or an accepted start.

## Operation
- **States and transitions**
  - IDLE → RUN on start; latches cfg_rows_m1/cfg_cols_m1 and clears all counters, the busy mask and err.
  - RUN → DONE when every active row r (0..rows-1) has done_cnt[r] == cols.
  - DONE → IDLE unconditionally after 1 cycle.
  - start is ignored outside IDLE.
- **Per-row state** (MAX_DIM entries, 5 bits each, range 0..16)
  - disp_cnt[r]: tiles dispatched in row r.
  - done_cnt[r]: tiles completed in row r.
- **Per-solver state**
  - sbusy[s]: solver s holds a tile.
  - srow[s]: row of the tile held by solver s.
- **Eligibility of row r**, in RUN:
  - r < rows;
  - disp_cnt[r] < cols;
  - disp_cnt[r] == done_cnt[r], i.e. at most one outstanding tile per row, so completions within a row arrive in column order;
  - r == 0, or done_cnt[r-1] > disp_cnt[r].
- **Dispatch** (at most one tile per cycle)
  - Choose the lowest eligible row r and the lowest-index solver s with !sbusy[s].
  - If both exist, register: solver_start = 1<<s, tile_row = r, tile_col = disp_cnt[r].
  - Then set sbusy[s], set srow[s] = r, and increment disp_cnt[r].
  - Otherwise solver_start = 0 and tile_row/tile_col hold their last values.
- **Completion**
  - For each s with solver_done[s] && sbusy[s]: clear sbusy[s] and increment done_cnt[srow[s]].
  - Several completions in one cycle always target distinct rows, so all are applied in that cycle.
  - solver_done[s] with !sbusy[s] sets err and is otherwise ignored.
  - solver_done in IDLE or DONE is treated the same way.
- **Same-cycle events**
  - A solver finishing in cycle k can be redispatched by the decision made in cycle k+1; the completion update is visible then.
  - A decision never uses a done arriving in the same cycle.
- **Arithmetic**
  - rows = cfg_rows_m1 + 1 and cols = cfg_cols_m1 + 1, both 5 bits, range 1..16. No wrap is possible.
- **Reset** (any time, including mid-grid)
  - Returns to IDLE and clears all state.
  - Output reset values: solver_start = 0, tile_row = 0, tile_col = 0, busy = 0, all_done = 0, err = 0.
  - In-flight solver results after reset raise err.

## Timing
- All outputs are registered.
- start in cycle k → busy high in k+1 → first dispatch (tile 0,0 to solver 0) asserted in cycle k+2.
- solver_done in cycle k → the earliest dependent dispatch is in cycle k+2.
- Last completion in cycle k → all_done high in cycle k+2; busy low in k+3.
- Peak dispatch rate is 1 tile/cycle. Solver latency is unbounded; the scheduler never times out.

## Test plan
- **1×1 grid**
  - Stimulus: cfg 0/0, start in cycle 0; solver_done[0] in cycle 5.
  - Required: solver_start = 0x0001 with row 0, col 0 in cycle 2; all_done in cycle 7; busy low in cycle 8.
- **2×2 grid, each solver answers 3 cycles after its start**
  - Required dispatch order: (0,0) to solver 0; then (0,1) and (1,0) on consecutive cycles to solvers 0 and 1, since solver 0 is freed first; then (1,1).
  - Required: never two pulses in one cycle.
- **16×16 grid, 16 solvers, random 1–20 cycle latencies**
  - Required: exactly 256 dispatches, each tile exactly once.
  - Required: every dispatch of (r,c) comes after the completions of (r-1,c) and (r,c-1).
  - Required: err stays 0; all_done fires once.
- **NUM_SOLVERS = 2 on a 4×4 grid**
  - Required: solver_start never targets a busy solver.
  - Required: simultaneous dones on both solvers are both counted, with the next two dispatches following on consecutive cycles.
- **Spurious inputs**
  - Stimulus: solver_done[7] while solver 7 is idle; start pulsed during RUN.
  - Required: err goes to 1 and stays; the run is unaffected; the second start is ignored.
- **Reset mid-run**
  - Stimulus: assert reset during an 8×8 run.
  - Required: all outputs go to 0 immediately (asynchronous).
  - Then: a new start with cfg 1/1 completes normally with 4 dispatches.
